// File: rtl/maxnet_sched_pkg.sv
// -----------------------------------------------------------------------------
// maxnet_sched_pkg
// Shared types for the MaxNet job scheduler:
//   - state_t  : sequencer states (IDLE, LOAD, ACT, MULT, ADD, CHECK, DONE)
//   - STATE_W  : state encoding width
//   - strobe_t : bundle of datapath write strobes plus the activation source select
//   - decode_strobes() : Moore decode of the strobe bundle from the current state
// -----------------------------------------------------------------------------
package maxnet_sched_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ACT   = 3'd2,
      ST_MULT  = 3'd3,
      ST_ADD   = 3'd4,
      ST_CHECK = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   typedef struct packed {
      logic mainRegWrite;
      logic actWrite;
      logic multWrite;
      logic addWrite;
      logic act_sel;
   } strobe_t;

   // first_iter is true while no iteration of the current job has completed;
   // the activation stage then reads the main register instead of the adder.
   function automatic strobe_t decode_strobes(input state_t st, input logic first_iter);
      strobe_t s;
      s = '0;
      case (st)
         ST_LOAD: s.mainRegWrite = 1'b1;
         ST_ACT: begin
            s.actWrite = 1'b1;
            s.act_sel  = ~first_iter;
         end
         ST_MULT: s.multWrite = 1'b1;
         ST_ADD:  s.addWrite  = 1'b1;
         default: s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/maxnet_rr_arbiter.sv
// -----------------------------------------------------------------------------
// maxnet_rr_arbiter
// Combinational round-robin arbiter. Picks the first set request bit after
// last_grant, wrapping around, so the most recent owner has lowest priority.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  ID_W     index of the previously served requester
//   grant      out ID_W     index of the winning requester (0 when none)
//   any_req    out 1        at least one request bit set
// -----------------------------------------------------------------------------
module maxnet_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_grant,
   output logic [ID_W-1:0]    grant,
   output logic               any_req
);

   int unsigned      pos;
   logic [ID_W-1:0]  idx;

   // NOTE: every variable assigned in this block receives a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant   = '0;
      any_req = |req;
      pos     = 0;
      idx     = '0;
      // Walk from the farthest offset to the nearest; the last hit wins,
      // which leaves the nearest set bit after last_grant as the grant.
      for (int off = NUM_REQ; off >= 1; off--) begin
         pos = (int'(unsigned'(last_grant)) + off) % NUM_REQ;
         idx = pos[ID_W-1:0];
         if (req[idx]) grant = idx;
      end
   end

endmodule

// File: rtl/maxnet_job_scheduler.sv
// -----------------------------------------------------------------------------
// maxnet_job_scheduler
// Round-robin job scheduler and sequencer for the shared MaxNet datapath.
// Grants one requester at a time, loads its input vector, then loops
// ACT -> MULT -> ADD -> CHECK until the datapath reports found (or, when
// MAXNET_SCHED_TIMEOUT_EN is defined, the iteration limit is reached), then
// acknowledges the requester for one cycle and returns to IDLE.
//
// Configuration macro: MAXNET_SCHED_TIMEOUT_EN
//   defined   : job ends after MAX_ITER iterations without found; timeout valid
//   undefined : loop runs until found; timeout tied 0; iter_count saturates
//
// Ports:
//   clk          in   1        system clock, rising edge
//   rst          in   1        synchronous active-high reset
//   req          in   NUM_REQ  per-requester level request, held until ack
//   found        in   1        datapath winner-found flag, sampled in CHECK
//   mainRegWrite out  1        load main register
//   actWrite     out  1        write activation register
//   multWrite    out  1        write multiplier register
//   addWrite     out  1        write adder register
//   act_sel      out  1        0 = activation from main register, 1 = feedback
//   grant_id     out  ID_W     current / last owner index
//   busy         out  1        job in progress (LOAD through DONE)
//   ack          out  NUM_REQ  one-hot one-cycle completion pulse
//   timeout      out  1        valid with ack; job hit the iteration limit
//   iter_count   out  ITER_W   completed iterations of current / last job
// -----------------------------------------------------------------------------
module maxnet_job_scheduler
   import maxnet_sched_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int MAX_ITER = 15,
   parameter int ITER_W   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       found,
   output logic                       mainRegWrite,
   output logic                       actWrite,
   output logic                       multWrite,
   output logic                       addWrite,
   output logic                       act_sel,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic [NUM_REQ-1:0]         ack,
   output logic                       timeout,
   output logic [ITER_W-1:0]          iter_count
);

   localparam int ID_W = $clog2(NUM_REQ);

   // Reject configurations the counters cannot represent.
   if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_ITER < 1 || MAX_ITER >= (1 << ITER_W)) begin : g_cfg_check
      $error("maxnet_job_scheduler: unsupported NUM_REQ/MAX_ITER/ITER_W combination");
   end

   state_t           state, state_nxt;
   strobe_t          strobes;
   logic [ID_W-1:0]  last_grant;
   logic [ID_W-1:0]  arb_grant;
   logic             any_req;
   logic [ITER_W-1:0] iter_next;
   logic             limit_hit;

   maxnet_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req        (req),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .any_req    (any_req)
   );

`ifdef MAXNET_SCHED_TIMEOUT_EN
   logic timeout_q;

   assign iter_next = iter_count + 1'b1;
   assign limit_hit = (iter_next == ITER_W'(MAX_ITER));
   assign timeout   = timeout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         timeout_q <= 1'b0;
      end else if (state == ST_LOAD) begin
         timeout_q <= 1'b0;
      end else if (state == ST_CHECK) begin
         // found wins over the limit when both occur in the same CHECK.
         timeout_q <= limit_hit & ~found;
      end
   end
`else
   // Without a limit the counter only reports progress; hold at all-ones
   // rather than wrapping so a long job never looks like a fresh one.
   assign iter_next = (&iter_count) ? iter_count : iter_count + 1'b1;
   assign limit_hit = 1'b0;
   assign timeout   = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Owner, fairness pointer and iteration counter. grant_id and iter_count
   // are only updated on grant/LOAD/CHECK, so they hold through IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_id   <= '0;
         last_grant <= ID_W'(NUM_REQ - 1);
         iter_count <= '0;
      end else begin
         case (state)
            ST_IDLE:  if (any_req) grant_id <= arb_grant;
            ST_LOAD:  iter_count <= '0;
            ST_CHECK: iter_count <= iter_next;
            ST_DONE:  last_grant <= grant_id;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      strobes   = decode_strobes(state, iter_count == '0);
      busy      = (state != ST_IDLE);
      ack       = '0;
      case (state)
         ST_IDLE:  if (any_req) state_nxt = ST_LOAD;
         ST_LOAD:  state_nxt = ST_ACT;
         ST_ACT:   state_nxt = ST_MULT;
         ST_MULT:  state_nxt = ST_ADD;
         ST_ADD:   state_nxt = ST_CHECK;
         ST_CHECK: state_nxt = (found || limit_hit) ? ST_DONE : ST_ACT;
         ST_DONE: begin
            ack[grant_id] = 1'b1;
            state_nxt     = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign mainRegWrite = strobes.mainRegWrite;
   assign actWrite     = strobes.actWrite;
   assign multWrite    = strobes.multWrite;
   assign addWrite     = strobes.addWrite;
   assign act_sel      = strobes.act_sel;

endmodule
